// File: rtl/seq_div16x8.sv
// seq_div16x8 -- sequential unsigned restoring divider, one quotient bit per clock.
//
// Ports:
//   clk          system clock, rising edge
//   reset_a      asynchronous active-high reset
//   start        request, only looked at while idle
//   dividend     DW-bit dividend, captured when a request is accepted
//   divisor      VW-bit divisor, captured when a request is accepted
//   busy         high while an operation is in flight, through the done_flag cycle
//   done_flag    one-cycle pulse when quotient/remainder are valid
//   quotient     DW-bit result, held until the next result
//   remainder    VW-bit result, held until the next result
//   div_by_zero  set together with the result when the divisor was zero
//
// State table:
//   IDLE | waiting for start; result outputs hold the last result
//   RUN  | one restoring shift/subtract step per clock, DW steps
//   DONE | single cycle; result copied to the outputs, back to IDLE
//
// busy and done_flag are registered from the state, so they lag it by one
// clock: a request accepted at edge N raises done_flag after edge N+DW+1.
module seq_div16x8 #(
  parameter int DW = 16,
  parameter int VW = 8
) (
  input  logic          clk,
  input  logic          reset_a,
  input  logic          start,
  input  logic [DW-1:0] dividend,
  input  logic [VW-1:0] divisor,
  output logic          busy,
  output logic          done_flag,
  output logic [DW-1:0] quotient,
  output logic [VW-1:0] remainder,
  output logic          div_by_zero
);

  localparam int CW = (DW > 1) ? $clog2(DW) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t        state;
  logic [DW-1:0] q_reg;
  logic [VW-1:0] d_reg;
  logic [VW:0]   r_reg;
  logic [CW-1:0] cnt;
  logic          zdiv;

  logic [VW:0]   r_sh;
  logic [VW:0]   t_val;

  // r_reg always stays below the divisor, so its top bit is zero and the
  // shifted value fits in VW+1 bits; a set MSB in t_val means "negative".
  always_comb begin
    r_sh  = {r_reg[VW-1:0], q_reg[DW-1]};
    t_val = r_sh - {1'b0, d_reg};
  end

  always_ff @(posedge clk or posedge reset_a) begin
    if (reset_a) begin
      state       <= IDLE;
      q_reg       <= '0;
      d_reg       <= '0;
      r_reg       <= '0;
      cnt         <= '0;
      zdiv        <= 1'b0;
      busy        <= 1'b0;
      done_flag   <= 1'b0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
    end else begin
      busy      <= (state != IDLE);
      done_flag <= (state == DONE);

      case (state)
        IDLE: begin
          if (start) begin
            if (divisor != '0) begin
              q_reg <= dividend;
              d_reg <= divisor;
              r_reg <= '0;
              cnt   <= '0;
              zdiv  <= 1'b0;
              state <= RUN;
            end else begin
              // Zero divisor skips the datapath; the result is preset here.
              zdiv        <= 1'b1;
              quotient    <= '1;
              remainder   <= dividend[VW-1:0];
              div_by_zero <= 1'b1;
              state       <= DONE;
            end
          end
        end

        RUN: begin
          q_reg <= {q_reg[DW-2:0], ~t_val[VW]};
          r_reg <= t_val[VW] ? r_sh : t_val;
          cnt   <= cnt + CW'(1);
          if (cnt == CW'(DW - 1)) begin
            state <= DONE;
          end
        end

        DONE: begin
          if (!zdiv) begin
            quotient    <= q_reg;
            remainder   <= r_reg[VW-1:0];
            div_by_zero <= 1'b0;
          end
          state <= IDLE;
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_div16x8.sv
module tb_seq_div16x8;

  logic        clk = 1'b0;
  logic        reset_a;
  logic        start;
  logic [15:0] dividend;
  logic [7:0]  divisor;
  logic        busy;
  logic        done_flag;
  logic [15:0] quotient;
  logic [7:0]  remainder;
  logic        div_by_zero;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  seq_div16x8 #(.DW(16), .VW(8)) dut (
    .clk        (clk),
    .reset_a    (reset_a),
    .start      (start),
    .dividend   (dividend),
    .divisor    (divisor),
    .busy       (busy),
    .done_flag  (done_flag),
    .quotient   (quotient),
    .remainder  (remainder),
    .div_by_zero(div_by_zero)
  );

  typedef struct {
    logic [15:0] a;
    logic [7:0]  b;
    logic [15:0] eq;
    logic [7:0]  er;
    logic        ez;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  // Issue one request, scramble the operand inputs right after acceptance,
  // then wait (bounded) for done_flag. lat counts edges after the accept edge.
  task automatic run_div(input logic [15:0] a, input logic [7:0] b,
                         output logic [15:0] q, output logic [7:0] r, output logic z,
                         output int lat, output int bcnt);
    @(negedge clk);
    start = 1'b1; dividend = a; divisor = b;
    @(posedge clk); #1;
    start = 1'b0; dividend = 16'($urandom); divisor = 8'($urandom);
    lat = -1; q = '0; r = '0; z = 1'b0;
    bcnt = busy ? 1 : 0;
    for (int k = 1; k <= 40; k++) begin
      @(posedge clk); #1;
      if (busy) bcnt++;
      if (done_flag) begin
        lat = k; q = quotient; r = remainder; z = div_by_zero;
        break;
      end
    end
  endtask

  vec_t        vecs[13];
  logic [15:0] q;
  logic [7:0]  r;
  logic        z;
  int          lat, bcnt, dcnt, first_done, second_done;

  initial begin
    vecs[0]  = '{16'd1000,  8'd7,   16'd142,   8'd6,    1'b0};
    vecs[1]  = '{16'd65535, 8'd255, 16'd257,   8'd0,    1'b0};
    vecs[2]  = '{16'd65535, 8'd1,   16'd65535, 8'd0,    1'b0};
    vecs[3]  = '{16'd5,     8'd9,   16'd0,     8'd5,    1'b0};
    vecs[4]  = '{16'd1234,  8'd0,   16'hFFFF,  8'hD2,   1'b1};
    vecs[5]  = '{16'd1000,  8'd7,   16'd142,   8'd6,    1'b0};
    vecs[6]  = '{16'd0,     8'd5,   16'd0,     8'd0,    1'b0};
    vecs[7]  = '{16'd40000, 8'd123, 16'd325,   8'd25,   1'b0};
    vecs[8]  = '{16'd255,   8'd255, 16'd1,     8'd0,    1'b0};
    vecs[9]  = '{16'd65535, 8'd2,   16'd32767, 8'd1,    1'b0};
    vecs[10] = '{16'd12345, 8'd100, 16'd123,   8'd45,   1'b0};
    vecs[11] = '{16'd100,   8'd200, 16'd0,     8'd100,  1'b0};
    vecs[12] = '{16'd0,     8'd0,   16'hFFFF,  8'd0,    1'b1};

    reset_a = 1'b1; start = 1'b0; dividend = '0; divisor = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_busy", busy, 0);
    chk("reset_done", done_flag, 0);
    chk("reset_quotient", quotient, 0);
    chk("reset_remainder", remainder, 0);
    chk("reset_dbz", div_by_zero, 0);
    @(negedge clk); reset_a = 1'b0;

    // Table-driven vectors
    for (int i = 0; i < 13; i++) begin
      run_div(vecs[i].a, vecs[i].b, q, r, z, lat, bcnt);
      chk($sformatf("v%0d_quotient", i), q, vecs[i].eq);
      chk($sformatf("v%0d_remainder", i), r, vecs[i].er);
      chk($sformatf("v%0d_dbz", i), z, vecs[i].ez);
      chk($sformatf("v%0d_latency", i), lat, vecs[i].ez ? 1 : 17);
      chk($sformatf("v%0d_busy_cycles", i), bcnt, vecs[i].ez ? 1 : 17);
      @(posedge clk); #1;
      chk($sformatf("v%0d_done_pulse", i), done_flag, 0);
      chk($sformatf("v%0d_busy_idle", i), busy, 0);
    end

    // Results held while idle with changing operand inputs
    run_div(16'd12345, 8'd100, q, r, z, lat, bcnt);
    repeat (5) begin
      @(negedge clk); dividend = 16'($urandom); divisor = 8'($urandom);
    end
    #1;
    chk("hold_quotient", quotient, 123);
    chk("hold_remainder", remainder, 45);

    // Second start during RUN is ignored
    @(negedge clk);
    start = 1'b1; dividend = 16'd300; divisor = 8'd10;
    @(posedge clk); #1;
    start = 1'b0;
    chk("accept_no_clear_quotient", quotient, 123);
    dcnt = 0; first_done = -1; q = '0; r = '0;
    for (int k = 1; k <= 40; k++) begin
      @(posedge clk); #1;
      if (done_flag) begin
        dcnt++;
        if (first_done < 0) begin
          first_done = k; q = quotient; r = remainder;
        end
      end
      if (k == 5) begin start = 1'b1; dividend = 16'd50; divisor = 8'd5; end
      if (k == 6) start = 1'b0;
    end
    chk("ignore_latency", first_done, 17);
    chk("ignore_done_count", dcnt, 1);
    chk("ignore_quotient", q, 30);
    chk("ignore_remainder", r, 0);

    // Reset mid-RUN aborts everything
    @(negedge clk);
    start = 1'b1; dividend = 16'd40000; divisor = 8'd123;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (8) @(posedge clk);
    #3;
    reset_a = 1'b1;
    #1;
    chk("abort_busy", busy, 0);
    chk("abort_done", done_flag, 0);
    chk("abort_quotient", quotient, 0);
    chk("abort_remainder", remainder, 0);
    chk("abort_dbz", div_by_zero, 0);
    @(negedge clk); reset_a = 1'b0;
    dcnt = 0;
    for (int k = 0; k < 25; k++) begin
      @(posedge clk); #1;
      if (done_flag) dcnt++;
    end
    chk("abort_no_done", dcnt, 0);
    run_div(16'd40000, 8'd123, q, r, z, lat, bcnt);
    chk("after_abort_quotient", q, 325);
    chk("after_abort_remainder", r, 25);
    chk("after_abort_latency", lat, 17);

    // start held high re-triggers in the first idle cycle
    @(negedge clk);
    start = 1'b1; dividend = 16'd1000; divisor = 8'd7;
    @(posedge clk); #1;
    dcnt = 0; first_done = -1; second_done = -1;
    for (int k = 1; k <= 60; k++) begin
      @(posedge clk); #1;
      if (done_flag) begin
        dcnt++;
        if (first_done < 0) first_done = k;
        else if (second_done < 0) begin
          second_done = k;
          start = 1'b0;
        end
      end
    end
    start = 1'b0;
    chk("held_first_done", first_done, 17);
    chk("held_second_done", second_done, 35);
    chk("held_done_count", dcnt, 2);
    chk("held_quotient", quotient, 142);

    // Random vectors against a reference model
    for (int i = 0; i < 200; i++) begin
      logic [15:0] ra;
      logic [7:0]  rb;
      ra = 16'($urandom);
      rb = 8'($urandom_range(1, 255));
      run_div(ra, rb, q, r, z, lat, bcnt);
      chk("rand_quotient", q, ra / rb);
      chk("rand_remainder", r, ra % rb);
      chk("rand_invariant", 32'(q) * 32'(rb) + 32'(r), 32'(ra));
      chk("rand_rem_lt_div", (r < rb) ? 1 : 0, 1);
      chk("rand_latency", lat, 17);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
